// File: rtl/ehgu_ram_dp_arbiter.sv
// ehgu_ram_dp_arbiter
// Shares one dual-port RAM between NREQ requesters. One write and one read
// are granted per cycle by independent round-robin arbiters; a read that
// targets the address being written in the same cycle is held off. Read
// data is returned one cycle after the grant to the requester that issued it.
module ehgu_ram_dp_arbiter #(
  parameter int NREQ   = 4,
  parameter int DEPTH  = 32,
  parameter int AWIDTH = $clog2(DEPTH),
  parameter int DWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*AWIDTH-1:0]   addr,
  input  logic [NREQ*DWIDTH-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DWIDTH-1:0]        rdata_out,
  output logic                     ram_wenable,
  output logic [AWIDTH-1:0]        ram_waddr,
  output logic [DWIDTH-1:0]        ram_wdata,
  output logic                     ram_renable,
  output logic [AWIDTH-1:0]        ram_raddr,
  input  logic [DWIDTH-1:0]        ram_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic              r_tag_vld;
  logic [PW-1:0]     r_tag_idx;

  logic [AWIDTH-1:0] w_addr_a  [NREQ];
  logic [DWIDTH-1:0] w_wdata_a [NREQ];
  logic [NREQ-1:0]   w_wcand;
  logic [NREQ-1:0]   w_rcand;
  logic              w_wfound;
  logic              w_rfound;
  logic [PW-1:0]     w_widx;
  logic [PW-1:0]     w_ridx;
  logic              w_wgrant;
  logic              w_rgrant;
  logic              w_hazard;

  // Unpack the flat per-requester buses into arrays
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_addr_a[i]  = addr[i*AWIDTH +: AWIDTH];
      w_wdata_a[i] = wdata[i*DWIDTH +: DWIDTH];
    end
  end

  assign w_wcand = req & we;
  assign w_rcand = req & ~we;

  // Round-robin search for the write winner, starting at r_wptr
  always_comb begin
    int unsigned idx;
    idx      = 0;
    w_wfound = 1'b0;
    w_widx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(r_wptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_wfound && w_wcand[idx[PW-1:0]]) begin
        w_wfound = 1'b1;
        w_widx   = idx[PW-1:0];
      end
    end
  end

  // Round-robin search for the read candidate, starting at r_rptr
  always_comb begin
    int unsigned idx;
    idx      = 0;
    w_rfound = 1'b0;
    w_ridx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(r_rptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_rfound && w_rcand[idx[PW-1:0]]) begin
        w_rfound = 1'b1;
        w_ridx   = idx[PW-1:0];
      end
    end
  end

  // Grants are suppressed while reset is held so the RAM sees no commands
  assign w_wgrant = w_wfound & ~rst;
  assign w_hazard = w_wgrant & w_rfound & (w_addr_a[w_ridx] == w_addr_a[w_widx]);
  assign w_rgrant = w_rfound & ~rst & ~w_hazard;

  // Drive grants and RAM controls from the two winners
  always_comb begin
    gnt = '0;
    if (w_wgrant) gnt[w_widx] = 1'b1;
    if (w_rgrant) gnt[w_ridx] = 1'b1;
  end

  assign ram_wenable = w_wgrant;
  assign ram_waddr   = w_addr_a[w_widx];
  assign ram_wdata   = w_wdata_a[w_widx];
  assign ram_renable = w_rgrant;
  assign ram_raddr   = w_addr_a[w_ridx];

  // Advance each pointer past its winner; hold it when nothing was granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wgrant) r_wptr <= (w_widx == PW'(NREQ-1)) ? '0 : w_widx + PW'(1);
      if (w_rgrant) r_rptr <= (w_ridx == PW'(NREQ-1)) ? '0 : w_ridx + PW'(1);
    end
  end

  // Remember which requester owns the read data arriving next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld <= 1'b0;
      r_tag_idx <= '0;
    end else begin
      r_tag_vld <= w_rgrant;
      if (w_rgrant) r_tag_idx <= w_ridx;
    end
  end

  // Steer the returned data to the tagged requester
  always_comb begin
    rvalid = '0;
    if (r_tag_vld) rvalid[r_tag_idx] = 1'b1;
  end

  assign rdata_out = ram_rdata;

endmodule
